branch_sequencer: RTL and testbench

- Consumer side of the stored zero flag: program-counter sequencer that reads the registered Z flag and resolves conditional jumps.
- Sits between the flag register and the instruction-memory address port of the 10-bit CPU.
- Each cycle it either increments the PC or loads a branch target, and it issues a one-cycle flush bubble after every taken branch.

---
 rtl/branch_sequencer_if.sv | 58 +++++
 rtl/branch_sequencer.sv | 133 +++++++++++++
 tb/tb_branch_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if
//   Groups the decode-side branch inputs and the fetch-side PC outputs of
//   branch_sequencer into one bundle.
//   Optional macro ZFWD_EN adds the forwarded ALU zero flag (z_alu) and the
//   flag write enable (ze).
//
//   Signals (direction as seen by the sequencer, i.e. the slave modport):
//     stall      in   hold PC and state this cycle
//     br_valid   in   branch instruction present in decode
//     br_op      in   00 none, 01 JMP, 10 JZ, 11 JNZ
//     br_target  in   absolute branch destination
//     z_ff       in   stored zero flag
//     z_alu      in   ALU zero output        (ZFWD_EN only)
//     ze         in   flag write enable      (ZFWD_EN only)
//     pc         out  current fetch address
//     pc_valid   out  pc is a valid fetch address
//     flush      out  one-cycle discard pulse after a taken branch
//     taken      out  one-cycle pulse, branch taken on previous edge
//     taken_cnt  out  saturating taken-branch count
interface branch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 8
);
  logic             stall;
  logic             br_valid;
  logic [1:0]       br_op;
  logic [PC_W-1:0]  br_target;
  logic             z_ff;
`ifdef ZFWD_EN
  logic             z_alu;
  logic             ze;
`endif
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             flush;
  logic             taken;
  logic [CNT_W-1:0] taken_cnt;

`ifdef ZFWD_EN
  modport master (
    output stall, br_valid, br_op, br_target, z_ff, z_alu, ze,
    input  pc, pc_valid, flush, taken, taken_cnt
  );
  modport slave (
    input  stall, br_valid, br_op, br_target, z_ff, z_alu, ze,
    output pc, pc_valid, flush, taken, taken_cnt
  );
`else
  modport master (
    output stall, br_valid, br_op, br_target, z_ff,
    input  pc, pc_valid, flush, taken, taken_cnt
  );
  modport slave (
    input  stall, br_valid, br_op, br_target, z_ff,
    output pc, pc_valid, flush, taken, taken_cnt
  );
`endif
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Program-counter sequencer for the 10-bit CPU. Each cycle it increments
//   the PC or loads a branch target resolved against the stored zero flag,
//   and inserts a one-cycle flush bubble after every taken branch.
//   Optional macro ZFWD_EN: resolve JZ/JNZ against the ALU zero output when
//   the flag is being written in the same cycle (removes the flag hazard).
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous active-low reset
//     bus  slave modport of branch_sequencer_if (branch inputs, PC outputs)
//
//   state | meaning
//   IDLE  | one cycle after reset release, pc=RESET_VEC not yet valid
//   RUN   | fetching; pc increments or loads a taken branch target
//   FLUSH | bubble after taken branch; pc holds target, pc_valid=0
module branch_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 8
) (
  input logic             clk,
  input logic             rst,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] OP_JMP = 2'b01;
  localparam logic [1:0] OP_JZ  = 2'b10;
  localparam logic [1:0] OP_JNZ = 2'b11;

  state_t           state_q,     state_nxt;
  logic [PC_W-1:0]  pc_q,        pc_nxt;
  logic             pc_valid_q,  pc_valid_nxt;
  logic             flush_q,     flush_nxt;
  logic             taken_q,     taken_nxt;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_nxt;

  logic cond_z;
  logic br_take;

`ifdef ZFWD_EN
  // A flag write in flight is newer than the stored flag.
  assign cond_z = bus.ze ? bus.z_alu : bus.z_ff;
`else
  assign cond_z = bus.z_ff;
`endif

  always_comb begin
    br_take = 1'b0;
    if (bus.br_valid) begin
      unique case (bus.br_op)
        OP_JMP:  br_take = 1'b1;
        OP_JZ:   br_take = cond_z;
        OP_JNZ:  br_take = ~cond_z;
        default: br_take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      pc_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      taken_q     <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      pc_q        <= pc_nxt;
      pc_valid_q  <= pc_valid_nxt;
      flush_q     <= flush_nxt;
      taken_q     <= taken_nxt;
      taken_cnt_q <= taken_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    pc_nxt        = pc_q;
    pc_valid_nxt  = pc_valid_q;
    flush_nxt     = 1'b0;
    taken_nxt     = 1'b0;
    taken_cnt_nxt = taken_cnt_q;

    unique case (state_q)
      IDLE: begin
        // stall deliberately ignored: start-up always takes one cycle
        state_nxt    = RUN;
        pc_nxt       = RESET_VEC;
        pc_valid_nxt = 1'b1;
      end
      RUN: begin
        if (!bus.stall) begin
          if (br_take) begin
            state_nxt     = FLUSH;
            pc_nxt        = bus.br_target;
            pc_valid_nxt  = 1'b0;
            flush_nxt     = 1'b1;
            taken_nxt     = 1'b1;
            taken_cnt_nxt = (&taken_cnt_q) ? taken_cnt_q : taken_cnt_q + 1'b1;
          end else begin
            pc_nxt = pc_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // flush/taken default low, so the pulse is one cycle even if stalled
        if (!bus.stall) begin
          state_nxt    = RUN;
          pc_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        pc_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.flush     = flush_q;
  assign bus.taken     = taken_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer
//   Directed test of branch_sequencer: reset/start, increment, wrap,
//   JZ/JNZ/JMP resolution, stall in RUN and FLUSH, counter saturation with a
//   self-loop, reset mid-FLUSH, and (with ZFWD_EN) flag forwarding.
module tb_branch_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  branch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_sequencer #(.PC_W(PC_W), .RESET_VEC('0), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_flush, input logic e_taken, input logic [31:0] e_cnt);
    check({tag, ".pc"},        {22'd0, bus.pc},       e_pc);
    check({tag, ".pc_valid"},  {31'd0, bus.pc_valid}, {31'd0, e_valid});
    check({tag, ".flush"},     {31'd0, bus.flush},    {31'd0, e_flush});
    check({tag, ".taken"},     {31'd0, bus.taken},    {31'd0, e_taken});
    check({tag, ".taken_cnt"}, {24'd0, bus.taken_cnt}, e_cnt);
  endtask

  task automatic branch(input logic v, input logic [1:0] op, input logic [9:0] tgt, input logic z);
    bus.br_valid  = v;
    bus.br_op     = op;
    bus.br_target = tgt;
    bus.z_ff      = z;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    branch(1'b0, 2'b00, 10'h000, 1'b0);
`ifdef ZFWD_EN
    bus.ze    = 1'b0;
    bus.z_alu = 1'b0;
`endif

    // reset and start
    step(); step();
    check_out("reset", 32'h000, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    step();
    check_out("start", 32'h000, 1'b1, 1'b0, 1'b0, 32'd0);
    step(); check_out("inc1", 32'h001, 1'b1, 1'b0, 1'b0, 32'd0);
    step(); check_out("inc2", 32'h002, 1'b1, 1'b0, 1'b0, 32'd0);
    step(); check_out("inc3", 32'h003, 1'b1, 1'b0, 1'b0, 32'd0);
    step(); step();
    check_out("at5", 32'h005, 1'b1, 1'b0, 1'b0, 32'd0);

    // JZ taken
    branch(1'b1, 2'b10, 10'h120, 1'b1);
    step();
    check_out("jz_taken", 32'h120, 1'b0, 1'b1, 1'b1, 32'd1);
    branch(1'b0, 2'b00, 10'h000, 1'b0);
    step(); check_out("jz_flush_exit", 32'h120, 1'b1, 1'b0, 1'b0, 32'd1);
    step(); check_out("jz_target_inc", 32'h121, 1'b1, 1'b0, 1'b0, 32'd1);

    // JZ not taken, JNZ not taken, JNZ taken
    branch(1'b1, 2'b10, 10'h200, 1'b0);
    step(); check_out("jz_not", 32'h122, 1'b1, 1'b0, 1'b0, 32'd1);
    branch(1'b1, 2'b11, 10'h200, 1'b1);
    step(); check_out("jnz_not", 32'h123, 1'b1, 1'b0, 1'b0, 32'd1);
    branch(1'b1, 2'b11, 10'h040, 1'b0);
    step(); check_out("jnz_taken", 32'h040, 1'b0, 1'b1, 1'b1, 32'd2);
    branch(1'b0, 2'b00, 10'h000, 1'b0);
    step(); check_out("jnz_flush_exit", 32'h040, 1'b1, 1'b0, 1'b0, 32'd2);

    // stall in RUN holds even with a JMP present
    bus.stall = 1'b1;
    branch(1'b1, 2'b01, 10'h300, 1'b0);
    step(); check_out("stall1", 32'h040, 1'b1, 1'b0, 1'b0, 32'd2);
    step(); check_out("stall2", 32'h040, 1'b1, 1'b0, 1'b0, 32'd2);
    step(); check_out("stall3", 32'h040, 1'b1, 1'b0, 1'b0, 32'd2);
    bus.stall = 1'b0;
    step(); check_out("jmp_after_stall", 32'h300, 1'b0, 1'b1, 1'b1, 32'd3);

    // stall in FLUSH: pulse stays one cycle wide
    bus.stall = 1'b1;
    branch(1'b0, 2'b00, 10'h000, 1'b0);
    step(); check_out("flush_stall1", 32'h300, 1'b0, 1'b0, 1'b0, 32'd3);
    step(); check_out("flush_stall2", 32'h300, 1'b0, 1'b0, 1'b0, 32'd3);
    bus.stall = 1'b0;
    step(); check_out("flush_stall_exit", 32'h300, 1'b1, 1'b0, 1'b0, 32'd3);
    step(); check_out("after_flush_inc", 32'h301, 1'b1, 1'b0, 1'b0, 32'd3);

    // wrap 0x3FF -> 0x000
    branch(1'b1, 2'b01, 10'h3FE, 1'b0);
    step(); check_out("jmp_3fe", 32'h3FE, 1'b0, 1'b1, 1'b1, 32'd4);
    branch(1'b0, 2'b00, 10'h000, 1'b0);
    step(); check_out("at_3fe", 32'h3FE, 1'b1, 1'b0, 1'b0, 32'd4);
    step(); check_out("at_3ff", 32'h3FF, 1'b1, 1'b0, 1'b0, 32'd4);
    step(); check_out("wrap", 32'h000, 1'b1, 1'b0, 1'b0, 32'd4);

    // br_op none with br_valid, and JMP without br_valid: never taken
    branch(1'b1, 2'b00, 10'h155, 1'b1);
    step(); check_out("op_none", 32'h001, 1'b1, 1'b0, 1'b0, 32'd4);
    branch(1'b0, 2'b01, 10'h155, 1'b1);
    step(); check_out("no_valid", 32'h002, 1'b1, 1'b0, 1'b0, 32'd4);

    // counter saturation via self-loop JMP 0x010
    branch(1'b1, 2'b01, 10'h010, 1'b0);
    for (int i = 0; i < 500; i++) step();
    check_out("cnt_254", 32'h010, 1'b1, 1'b0, 1'b0, 32'd254);
    step(); step();
    check_out("cnt_255", 32'h010, 1'b1, 1'b0, 1'b0, 32'd255);
    for (int i = 0; i < 18; i++) step();
    check_out("cnt_sat", 32'h010, 1'b1, 1'b0, 1'b0, 32'd255);
    step();
    check_out("selfloop_flush", 32'h010, 1'b0, 1'b1, 1'b1, 32'd255);

    // reset mid-FLUSH, stall asserted too
    rst = 1'b0;
    bus.stall = 1'b1;
    branch(1'b0, 2'b00, 10'h000, 1'b0);
    step(); check_out("reset_in_flush", 32'h000, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    step(); check_out("idle_ignores_stall", 32'h000, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.stall = 1'b0;

    // flag forwarding (or its absence): stored flag 0, ALU flag 1, JZ
    branch(1'b1, 2'b10, 10'h055, 1'b0);
`ifdef ZFWD_EN
    bus.ze    = 1'b1;
    bus.z_alu = 1'b1;
    step(); check_out("zfwd_jz", 32'h055, 1'b0, 1'b1, 1'b1, 32'd1);
    bus.ze    = 1'b0;
    bus.z_alu = 1'b0;
`else
    step(); check_out("nofwd_jz", 32'h001, 1'b1, 1'b0, 1'b0, 32'd0);
`endif
    branch(1'b0, 2'b00, 10'h000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
